// File: rtl/debounce_bank_if.sv
// Signal bundle for debounce_bank: raw inputs and repeat enables in,
// conditioned levels and single-cycle event pulses out.
interface debounce_bank_if #(
    parameter int CHANNELS = 16
);
    logic [CHANNELS-1:0] noisy;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] clean;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] press;
    logic                any_active;

    modport master (
        output noisy,
        output repeat_en,
        input  clean,
        input  rise,
        input  fall,
        input  press,
        input  any_active
    );

    modport slave (
        input  noisy,
        input  repeat_en,
        output clean,
        output rise,
        output fall,
        output press,
        output any_active
    );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: two-flop synchronizer, stable-count debounce,
// registered rise/fall pulses and per-channel auto-repeat on press.
//
// state  | meaning
// IDLE   | clean is low, no repeat activity
// DELAY  | clean is high, counting the initial hold before the first repeat
// REPEAT | clean is high, emitting a press every REPEAT_RATE cycles
module debounce_bank #(
    parameter int CHANNELS        = 16,
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_RATE     = 6500000,
    parameter int B_DB            = $clog2(DEBOUNCE_CYCLES),
    parameter int B_RPT           = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE)
) (
    input  logic           clock,
    input  logic           reset_n,
    debounce_bank_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam logic [B_DB-1:0]  DB_LAST    = B_DB'(DEBOUNCE_CYCLES - 1);
    localparam logic [B_RPT-1:0] DELAY_LAST = B_RPT'(REPEAT_DELAY - 1);
    localparam logic [B_RPT-1:0] RATE_LAST  = B_RPT'(REPEAT_RATE - 1);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] clean_q;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] press_q;
    logic                any_q;

    logic [CHANNELS-1:0] clean_d;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;
    logic [CHANNELS-1:0] tick_d;

    logic [B_DB-1:0]     cnt_q  [CHANNELS];
    logic [B_DB-1:0]     cnt_d  [CHANNELS];
    rpt_state_t          state_q [CHANNELS];
    rpt_state_t          state_d [CHANNELS];
    logic [B_RPT-1:0]    rcnt_q [CHANNELS];
    logic [B_RPT-1:0]    rcnt_d [CHANNELS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.noisy;
            sync2 <= sync1;
        end
    end

    // Any sample that agrees with the current level restarts the stability count.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != clean_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    clean_d[i] = sync2[i];
                    rise_d[i]  = sync2[i];
                    fall_d[i]  = ~sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Release is judged on the level being written this edge, so a tick that
    // coincides with the falling update is dropped.
    always_comb begin
        tick_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (rise_d[i]) begin
                        state_d[i] = DELAY;
                        rcnt_d[i]  = '0;
                    end
                end
                DELAY: begin
                    if (!clean_d[i]) begin
                        state_d[i] = IDLE;
                        rcnt_d[i]  = '0;
                    end else if (!bus.repeat_en[i]) begin
                        rcnt_d[i] = '0;
                    end else if (rcnt_q[i] == DELAY_LAST) begin
                        tick_d[i]  = 1'b1;
                        rcnt_d[i]  = '0;
                        state_d[i] = REPEAT;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!clean_d[i]) begin
                        state_d[i] = IDLE;
                        rcnt_d[i]  = '0;
                    end else if (!bus.repeat_en[i]) begin
                        state_d[i] = DELAY;
                        rcnt_d[i]  = '0;
                    end else if (rcnt_q[i] == RATE_LAST) begin
                        tick_d[i] = 1'b1;
                        rcnt_d[i] = '0;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    rcnt_d[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            press_q <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
                rcnt_q[i]  <= '0;
            end
        end else begin
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= rise_d | tick_d;
            any_q   <= |clean_q;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
        end
    end

    assign bus.clean      = clean_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.press      = press_q;
    assign bus.any_active = any_q;
endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed stimulus, a window/time-anchored reference
// model compared every cycle, and literal expectations at key cycles.
module tb_debounce_bank;
    localparam int CH = 4;
    localparam int DB = 4;
    localparam int DL = 10;
    localparam int RT = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clock = ~clock;

    debounce_bank_if #(.CHANNELS(CH)) bus ();

    debounce_bank #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (DL),
        .REPEAT_RATE    (RT)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Reference model: clean flips when the last DB synchronised samples all
    // disagree with it; repeat ticks are timed from the latest anchor (rise or
    // a disabled cycle) as DL, DL+RT, DL+2RT, ...
    bit          hist [CH][DB+1];
    bit [CH-1:0] m_clean, m_rise, m_fall, m_press;
    bit          m_any;
    bit          active [CH];
    int          anchor [CH];
    int          edge_n;

    always @(posedge clock or negedge reset_n) begin : model
        bit changed, r, f, tk;
        int d;
        if (!reset_n) begin
            for (int ch = 0; ch < CH; ch++) begin
                for (int k = 0; k <= DB; k++) hist[ch][k] = 1'b0;
                active[ch] = 1'b0;
                anchor[ch] = 0;
            end
            m_clean = '0; m_rise = '0; m_fall = '0; m_press = '0; m_any = 1'b0;
            edge_n  = 0;
        end else begin
            edge_n++;
            m_any = |m_clean;
            for (int ch = 0; ch < CH; ch++) begin
                changed = 1'b1;
                for (int k = 1; k <= DB; k++)
                    if (hist[ch][k] == m_clean[ch]) changed = 1'b0;
                r = 1'b0; f = 1'b0; tk = 1'b0;
                if (changed) begin
                    m_clean[ch] = ~m_clean[ch];
                    r = m_clean[ch];
                    f = ~m_clean[ch];
                end
                if (r) begin
                    active[ch] = 1'b1;
                    anchor[ch] = edge_n;
                end else if (active[ch]) begin
                    if (!m_clean[ch]) active[ch] = 1'b0;
                    else if (!bus.repeat_en[ch]) anchor[ch] = edge_n;
                    else begin
                        d  = edge_n - anchor[ch];
                        tk = (d == DL) || (d > DL && ((d - DL) % RT) == 0);
                    end
                end
                for (int k = DB; k >= 1; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = bus.noisy[ch];
                m_rise[ch]  = r;
                m_fall[ch]  = f;
                m_press[ch] = r | tk;
            end
        end
    end

    always @(negedge clock) begin
        chk("cmp_clean", bus.clean, m_clean);
        chk("cmp_rise",  bus.rise,  m_rise);
        chk("cmp_fall",  bus.fall,  m_fall);
        chk("cmp_press", bus.press, m_press);
        chk("cmp_any",   bus.any_active, m_any);
    end

    initial begin
        logic        seen;
        logic [40:0] pmask, emask;
        logic [7:0]  glitch;
        int          pcount;

        bus.noisy     = '0;
        bus.repeat_en = '0;
        #1 reset_n = 1'b0;
        step(3);
        chk("rst_clean", bus.clean, 0);
        chk("rst_press", bus.press, 0);
        chk("rst_any",   bus.any_active, 0);
        reset_n = 1'b1;

        // basic debounce on channel 0
        bus.noisy[0] = 1'b1;
        step(5);
        chk("basic_clean_edge5", bus.clean[0], 0);
        step(1);
        chk("basic_clean_edge6", bus.clean[0], 1);
        chk("basic_rise_edge6",  bus.rise[0], 1);
        chk("basic_press_edge6", bus.press[0], 1);
        chk("basic_any_edge6",   bus.any_active, 0);
        step(1);
        chk("basic_rise_edge7",  bus.rise[0], 0);
        chk("basic_any_edge7",   bus.any_active, 1);
        bus.noisy[0] = 1'b0;
        step(6);
        chk("basic_fall", bus.fall[0], 1);
        chk("basic_fall_clean", bus.clean[0], 0);
        step(2);

        // glitch rejection on channel 1
        glitch = 8'b0111_0111;
        seen   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.noisy[1] = (k < 8) ? glitch[k] : 1'b0;
            step(1);
            seen = seen | bus.clean[1] | bus.rise[1] | bus.fall[1] | bus.press[1];
        end
        chk("glitch_quiet", seen, 0);

        // auto-repeat on channel 2
        bus.repeat_en[2] = 1'b1;
        bus.noisy[2]     = 1'b1;
        step(6);
        chk("rpt_rise",  bus.rise[2], 1);
        chk("rpt_press0", bus.press[2], 1);
        pmask  = '0;
        pcount = 0;
        for (int off = 1; off <= 40; off++) begin
            step(1);
            pmask[off] = bus.press[2];
            if (bus.press[2]) pcount++;
        end
        emask = '0;
        for (int k = DL; k <= 40; k += RT) emask[k] = 1'b1;
        chk("rpt_mask", pmask, emask);
        chk("rpt_count", pcount, 11);
        bus.noisy[2] = 1'b0;
        step(6);
        chk("rpt_release_fall",  bus.fall[2], 1);
        chk("rpt_release_press", bus.press[2], 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            seen = seen | bus.press[2];
        end
        chk("rpt_after_release", seen, 0);

        // repeat-enable toggle mid-hold
        bus.noisy[2] = 1'b1;
        step(6);
        chk("tog_rise", bus.rise[2], 1);
        seen = 1'b0;
        for (int off = 1; off <= 30; off++) begin
            step(1);
            if (off == 10) chk("tog_first_press", bus.press[2], 1);
            if (off >= 11 && off <= 29) seen = seen | bus.press[2];
            if (off == 30) chk("tog_press_t30", bus.press[2], 1);
            if (off == 12) bus.repeat_en[2] = 1'b0;
            if (off == 20) bus.repeat_en[2] = 1'b1;
        end
        chk("tog_quiet", seen, 0);
        bus.noisy[2]     = 1'b0;
        bus.repeat_en[2] = 1'b0;
        step(8);

        // simultaneous channels
        bus.noisy = 4'b1111;
        step(5);
        chk("sim_rise_early", bus.rise, 4'b0000);
        step(1);
        chk("sim_rise", bus.rise, 4'b1111);
        step(1);
        bus.noisy[3] = 1'b0;
        step(6);
        chk("sim_fall", bus.fall, 4'b1000);
        chk("sim_clean", bus.clean, 4'b0111);
        bus.noisy[3] = 1'b1;
        step(7);
        chk("sim_all_high", bus.clean, 4'b1111);

        // asynchronous reset mid-operation
        #2 reset_n = 1'b0;
        #1;
        chk("arst_clean", bus.clean, 0);
        chk("arst_fall",  bus.fall, 0);
        chk("arst_any",   bus.any_active, 0);
        step(2);
        chk("arst_fall_held", bus.fall, 0);
        reset_n = 1'b1;
        step(5);
        chk("arst_rise_early", bus.rise, 4'b0000);
        step(1);
        chk("arst_rise", bus.rise, 4'b1111);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer with edge detection and per-channel auto-repeat. It replaces the per-signal debouncer instances in the Nexys top level: one instance conditions every button and switch, and provides level, edge and key-repeat pulses. The repeat pulses drive cursor and grid-edit logic without extra pulse-stretching or edge-detect glue.

## Interface
- `CHANNELS`, 16: number of independent input channels.
- `DEBOUNCE_CYCLES`, 650000: stable-input cycles needed before `clean` changes (10 ms at 65 MHz); must be ≥ 2.
- `REPEAT_DELAY`, 32500000: cycles from press to first auto-repeat pulse (0.5 s); must be ≥ 2.
- `REPEAT_RATE`, 6500000: cycles between subsequent auto-repeat pulses (0.1 s); must be ≥ 2.
- `B_DB`, $clog2(DEBOUNCE_CYCLES): debounce counter width.
- `B_RPT`, $clog2(max(REPEAT_DELAY, REPEAT_RATE)): repeat counter width.

Ports:
- `clock`  in  1: single system clock; all logic is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `noisy`  in  CHANNELS: raw asynchronous inputs.
- `repeat_en`  in  CHANNELS: per-channel auto-repeat enable (synchronous to `clock`).
- `clean`  out  CHANNELS: debounced level.
- `rise`  out  CHANNELS: 1-cycle pulse on each 0→1 transition of `clean`.
- `fall`  out  CHANNELS: 1-cycle pulse on each 1→0 transition of `clean`.
- `press`  out  CHANNELS: `rise` OR'ed with auto-repeat ticks; 1-cycle pulses.
- `any_active`  out  1: OR-reduction of `clean`, registered.

## Operation
- **Reset** (async, `reset_n` = 0):
  - All synchronizer flops, `clean`, `rise`, `fall`, `press` and `any_active` are 0.
  - All counters are 0; every repeat FSM is in IDLE.
- **Synchronizer:** each channel has a two-flop synchronizer, `s1` → `s`. Only `s` is used downstream.
- **Debounce**, per channel, at every edge:
  - if `s` == `clean`: `cnt` ← 0;
  - else if `cnt` == DEBOUNCE_CYCLES−1: `clean` ← `s`, `cnt` ← 0;
  - else: `cnt` ← `cnt`+1.
- A glitch shorter than DEBOUNCE_CYCLES restarts the count and never changes `clean`.
- **Edges:**
  - `rise`/`fall` are registered together with the `clean` update.
  - They are high exactly in the first cycle `clean` shows its new value.
  - `rise` and `fall` on the same channel are never high together.
- **Repeat FSM**, per channel, states IDLE, DELAY, REPEAT, counter `rcnt`:
  - IDLE: on the `clean` 0→1 update → DELAY, `rcnt` ← 0.
  - DELAY: if `clean` = 0 → IDLE. Else if `repeat_en` = 0, hold DELAY with `rcnt` ← 0. Else if `rcnt` == REPEAT_DELAY−1, pulse `press`, `rcnt` ← 0, → REPEAT. Else `rcnt`+1.
  - REPEAT: if `clean` = 0 → IDLE. Else if `repeat_en` = 0 → DELAY with `rcnt` ← 0. Else if `rcnt` == REPEAT_RATE−1, pulse `press`, `rcnt` ← 0. Else `rcnt`+1.
- **Press output:** `press` = `rise` | repeat tick; both are registered, so there is no combinational path from the inputs.
- **Channel independence:** channels share no state, and simultaneous events on different channels are all reported in the same cycle.
- **Counter widths:** counters never wrap. The terminal compare always fires before overflow.

## Timing
- **Debounce latency:**
  - `noisy` changes and stays stable.
  - `clean`, plus `rise` or `fall`, changes at the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples the new value.
  - The extra 2 cycles are the synchronizer.
- **Repeat timing:** if `clean` rises at cycle t and `repeat_en` is held high:
  - first repeat `press` at t+REPEAT_DELAY;
  - further pulses at t+REPEAT_DELAY+k·REPEAT_RATE, k ≥ 1.
- **Release:**
  - `clean` 1→0 in cycle u: `fall` = 1 in u and no `press` in u or after.
  - If a repeat tick and the release fall in the same edge, the release wins: no `press` is issued.
- **`repeat_en` deasserted mid-hold:** the next repeat pulse comes a full REPEAT_DELAY after re-enable.
- **`any_active`** lags `clean` by one cycle.
- **Reset mid-operation:** all outputs go to 0 immediately, without waiting for the clock, and no `fall` pulse is produced. If an input is held high through reset, `rise` occurs DEBOUNCE_CYCLES+2 edges after `reset_n` deasserts.

## Test plan
Bench parameters: CHANNELS=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, `repeat_en`=0 unless stated.

- **Basic debounce:** `noisy[0]` steps 0→1 and is held → `clean[0]`=1 and `rise[0]`=1 (single cycle) at the 6th edge; `press[0]`=1 in the same cycle; `any_active`=1 one cycle later.
- **Glitch rejection:** `noisy[1]` toggles high for 3 cycles, low for 1, high for 3, then low → `clean[1]` stays 0, and no `rise`/`fall`/`press` ever occurs.
- **Auto-repeat:** `repeat_en[2]`=1, `noisy[2]` held high for 40 cycles after `clean` rises at t → `press[2]` at t, t+10, t+13, t+16, …. Release → `fall[2]` after 6 edges and no further `press`.
- **Repeat-enable toggle:** `repeat_en[2]` drops at t+12 and returns at t+20 → no `press` between t+11 and t+29; next `press` at t+30.
- **Simultaneous channels:** `noisy[3:0]` = 4'b1111 in one edge → `rise` = 4'b1111 in one cycle. Then channel 3 is released alone → `fall` = 4'b1000 only.
- **Reset mid-operation:** `reset_n` is pulled low asynchronously while `clean`=4'b1111 → all outputs 0 with no clock edge and no `fall` pulse. After release with inputs still high → `rise` = 4'b1111 at the 6th edge.
